ysyx_25040111_ifu: RTL
======================

Name: ysyx_25040111_ifu

Overview:
- Instruction fetch unit, directly downstream of the PC unit.
- Latches the one-cycle `pc_valid` pulse and the `pc` value from the PC unit, then issues a single-beat read on an AXI4-Lite-style read channel.
- Hands the fetched instruction and its PC to the decode stage over a valid/ready handshake.
- Detects misaligned PCs, bus error responses and bus timeouts, and reports each as a fetch fault.

Parameters:
- ADDR_W, 32, address and PC width.
- DATA_W, 32, instruction/read-data width.
- TMO_W, 8, timeout counter width; the timeout limit is 2^TMO_W-1 cycles waiting in ADDR or DATA.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- pc_valid  in  1  one-cycle pulse from the PC unit: a new pc is available.
- pc  in  ADDR_W  fetch address.
- araddr  out  ADDR_W  read address.
- arvalid  out  1  read address valid.
- arready  in  1  read address accepted.
- rdata  in  DATA_W  read data.
- rresp  in  2  read response; 2'b00 is OKAY, anything else is an error.
- rvalid  in  1  read data valid.
- rready  out  1  read data accept.
- inst  out  DATA_W  fetched instruction.
- inst_pc  out  ADDR_W  PC of `inst`.
- inst_valid  out  1  `inst`/`inst_pc`/`fault` valid to decode.
- inst_ready  in  1  decode accepts.
- fault  out  2  fault code: 0 none, 1 misaligned, 2 bus error, 3 timeout.
- busy  out  1  FSM not in IDLE.
- overrun  out  1  sticky: `pc_valid` arrived while busy.

Behaviour:
- Reset (synchronous, active-high, highest priority): state=IDLE.
  - Zeroed: `arvalid`, `rready`, `inst_valid`, `inst`, `inst_pc`, `fault`, `overrun`, timeout counter.
  - `araddr`=32'h0.
  - Applies mid-transaction. The bus is abandoned; the bench must also reset the slave.
- States: IDLE, ADDR, DATA, HOLD.
- IDLE:
  - On `pc_valid`, latch `pc` into `inst_pc` and `araddr`.
  - If `pc[1:0]`!=0: go to HOLD with fault=1 and `inst`=0. No bus access.
  - Otherwise: go to ADDR with `arvalid`=1.
- ADDR:
  - `arvalid` and `araddr` stay stable until `arready`.
  - On `arvalid` && `arready`: deassert `arvalid`, set `rready`=1, go to DATA.
- DATA:
  - On `rvalid` && `rready`: capture `rdata` into `inst`; fault=2 if `rresp`!=0, else 0.
  - Then deassert `rready`, go to HOLD.
  - An `rvalid` in the same cycle as the AR handshake is not sampled. The read is sampled only from DATA.
- HOLD:
  - `inst_valid`=1; `inst`, `inst_pc` and `fault` held stable.
  - On `inst_ready`: `inst_valid`=0 on the next edge, go to IDLE.
- Timeout counter:
  - Cleared on entry to ADDR and on the AR→DATA transition.
  - Increments each cycle spent in ADDR or DATA.
  - On reaching 2^TMO_W-1: drop `arvalid`/`rready`, `inst`=0, fault=3, go to HOLD.
  - Any late `rvalid` from that transaction while in HOLD or IDLE is ignored (`rready`=0).
- Latency:
  - Minimum `pc_valid` to `inst_valid` is 3 cycles with a zero-wait slave (IDLE→ADDR→DATA→HOLD).
  - A misaligned PC reaches HOLD after 1 cycle.
- `pc_valid` while busy:
  - The new pc is dropped, the current fetch is unaffected, and `overrun` is set.
  - `overrun` clears only on reset.
  - `pc_valid` coinciding with the HOLD→IDLE transition is also dropped; it is accepted only when sampled in IDLE.
- `busy` = (state != IDLE), combinational.
- Widths:
  - `inst_pc` and `araddr` are the PC truncated or extended to ADDR_W. No arithmetic is performed on the PC.

Decomposition:
- Shared header (existing inc.vh):
  - state encodings: IFU_IDLE 2'd0, IFU_ADDR 2'd1, IFU_DATA 2'd2, IFU_HOLD 2'd3;
  - fault codes: FLT_NONE, FLT_MISALIGN, FLT_BUSERR, FLT_TMO;
  - AXI response code OKAY = 2'b00.
- One sub-module: ysyx_25040111_ifu_tmo, a clear/enable saturating counter with terminal-count output.
- FSM and datapath registers stay in the top module.

Test Plan:
- Zero-wait slave: `pc_valid` with `pc`=32'h80000000 and `rdata`=32'h00000413 (`arready`/`rvalid` asserted immediately) -> `inst_valid` high 3 cycles after the pulse, `inst`=32'h00000413, `inst_pc`=32'h80000000, fault=0.
- Backpressure: slave holds `arready` low 4 cycles; decode holds `inst_ready` low 5 cycles -> `araddr` and `arvalid` stable throughout; `inst`/`inst_pc` stable while `inst_valid` && !`inst_ready`; single transfer only.
- Misaligned: `pc`=32'h80000002 -> no `arvalid` ever asserted, `inst_valid` next cycle, fault=1, `inst`=0.
- Bus error: `rresp`=2'b10 with `rdata`=32'hDEADBEEF -> fault=2, `inst`=32'hDEADBEEF, `inst_pc` correct.
- Timeout and overrun: slave never raises `arready`; a second `pc_valid` is given mid-wait -> after 255 cycles in ADDR, fault=3 and `inst_valid`=1; `overrun`=1 and stays 1; the second pc is never fetched.
- Reset mid-fetch: assert `reset` in DATA -> next edge: state IDLE, `arvalid`=`rready`=`inst_valid`=0, `fault`=0, `overrun`=0. A subsequent `pc_valid` to 32'h30000000 fetches normally.

Source files
------------

// File: rtl/ysyx_25040111_ifu_pkg.sv
// Shared encodings for the instruction fetch unit.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ysyx_25040111_ifu_pkg;

  // Fetch FSM states; the encodings match the long-standing inc.vh values.
  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_ADDR = 2'd1,
    IFU_DATA = 2'd2,
    IFU_HOLD = 2'd3
  } ifu_state_e;

  // Fault codes reported to decode alongside the instruction.
  typedef enum logic [1:0] {
    FLT_NONE     = 2'd0,
    FLT_MISALIGN = 2'd1,
    FLT_BUSERR   = 2'd2,
    FLT_TMO      = 2'd3
  } ifu_fault_e;

  // AXI read response code for a successful read.
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Instructions are word aligned; any set low address bit is a fault.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_25040111_ifu_tmo.sv
// Bus wait watchdog: clear/enable counter that saturates at all-ones.
// Latency: tc is combinational, high in the cycle whose edge takes the count to all-ones.
// Backpressure: none; counts whenever enabled.
module ysyx_25040111_ifu_tmo #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] cnt;

  // Count enabled cycles; a clear wins over counting and the count never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Terminal count: this edge is the one that reaches the limit.
  assign tc = en && !clr && (cnt == (MAX - 1'b1));

endmodule

// File: rtl/ysyx_25040111_ifu.sv
// Instruction fetch: latches a PC pulse, issues one AXI4-Lite read, hands inst/pc/fault to decode.
// Latency: pc_valid to inst_valid is 3 cycles with a zero-wait slave, 1 cycle for a misaligned PC.
// Backpressure: result held in HOLD until inst_ready; pc_valid while busy is dropped and flagged in overrun.
module ysyx_25040111_ifu
  import ysyx_25040111_ifu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TMO_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [1:0]        fault,
  output logic              busy,
  output logic              overrun
);

  ifu_state_e state_q;
  ifu_state_e state_d;
  ifu_fault_e fault_q;

  logic accept;
  logic ar_fire;
  logic r_fire;
  logic tmo_clr;
  logic tmo_en;
  logic tmo_hit;

  // A new PC is only taken when idle; anything else counts as an overrun.
  assign accept  = pc_valid && (state_q == IFU_IDLE);
  assign ar_fire = arvalid && arready;
  // Read data is only sampled from DATA, so an rvalid overlapping the AR handshake is ignored.
  assign r_fire  = rvalid && rready && (state_q == IFU_DATA);

  // Restart the watchdog when a read starts and again when its address phase completes.
  assign tmo_clr = accept || ((state_q == IFU_ADDR) && ar_fire);
  assign tmo_en  = (state_q == IFU_ADDR) || (state_q == IFU_DATA);

  ysyx_25040111_ifu_tmo #(
    .W (TMO_W)
  ) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr   (tmo_clr),
    .en    (tmo_en),
    .tc    (tmo_hit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IFU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a completed handshake beats a timeout landing on the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IFU_IDLE: begin
        if (pc_valid) begin
          state_d = is_misaligned(pc[1:0]) ? IFU_HOLD : IFU_ADDR;
        end
      end
      IFU_ADDR: begin
        if (ar_fire) begin
          state_d = IFU_DATA;
        end else if (tmo_hit) begin
          state_d = IFU_HOLD;
        end
      end
      IFU_DATA: begin
        if (r_fire || tmo_hit) begin
          state_d = IFU_HOLD;
        end
      end
      IFU_HOLD: begin
        if (inst_ready) begin
          state_d = IFU_IDLE;
        end
      end
      default: state_d = IFU_IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      arvalid    <= (state_d == IFU_ADDR);
      rready     <= (state_d == IFU_DATA);
      inst_valid <= (state_d == IFU_HOLD);
    end
  end

  // Address capture: araddr and inst_pc only change when a new PC is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      araddr  <= '0;
      inst_pc <= '0;
    end else if (accept) begin
      araddr  <= pc;
      inst_pc <= pc;
    end
  end

  // Result capture: instruction word and fault code for the hand-off to decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst    <= '0;
      fault_q <= FLT_NONE;
    end else if (accept && is_misaligned(pc[1:0])) begin
      inst    <= '0;
      fault_q <= FLT_MISALIGN;
    end else if (r_fire) begin
      inst    <= rdata;
      fault_q <= (rresp == RESP_OKAY) ? FLT_NONE : FLT_BUSERR;
    end else if (tmo_hit && (state_d == IFU_HOLD)) begin
      inst    <= '0;
      fault_q <= FLT_TMO;
    end
  end

  // Sticky flag for a PC pulse that arrived while a fetch was in flight or being held.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (pc_valid && (state_q != IFU_IDLE)) begin
      overrun <= 1'b1;
    end
  end

  assign fault = fault_q;
  assign busy  = (state_q != IFU_IDLE);

endmodule
